rx_sync_ctrl: RTL



---
 rtl/rx_sync_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: receive-side sequencer for the PRBS descrambler.
// Seeds the keystream generator, hunts for sync-word alignment on the
// incoming stream, tracks lock with hysteresis and forwards descrambled
// beats through a single output register.
module rx_sync_ctrl #(
    parameter logic [31:0] C_SYNC_WORD     = 32'hA5A5_5A5A,
    parameter int          C_LOCK_FRAMES   = 4,
    parameter int          C_UNLOCK_FRAMES = 3,
    parameter int          C_CNT_WIDTH     = 16
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic                   i_rx_enable,
    input  logic [31:0]            i_prbs_seed,
    input  logic                   i_clr_stats,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_sof,
    input  logic [31:0]            s_axis_tdata,
    output logic                   o_prbs_load,
    output logic [31:0]            o_prbs_seed,
    output logic                   o_prbs_step,
    input  logic [31:0]            i_prbs,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_sof,
    output logic [31:0]            m_axis_tdata,
    output logic                   o_locked,
    output logic [1:0]             o_state,
    output logic [C_CNT_WIDTH-1:0] o_err_count,
    output logic [C_CNT_WIDTH-1:0] o_frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_HUNT  = 2'd2,
        ST_TRACK = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_N   = 4'(C_LOCK_FRAMES);
    localparam logic [3:0] UNLOCK_N = 4'(C_UNLOCK_FRAMES);

    state_t                 state_q, state_d;
    logic [3:0]             match_cnt_q, match_cnt_d;
    logic [3:0]             miss_cnt_q, miss_cnt_d;
    logic                   seen_sof_q, seen_sof_d;
    logic [C_CNT_WIDTH-1:0] err_q, err_d, frame_q, frame_d;
    logic                   mvld_q, mvld_d, msof_q, msof_d;
    logic [31:0]            mdata_q, mdata_d;
    logic                   step;

    // Input side: only accept while hunting/tracking and the output slot can drain.
    logic ready, accept, sof_acc, match;
    assign ready   = ((state_q == ST_HUNT) || (state_q == ST_TRACK)) && i_rx_enable
                     && (!mvld_q || m_axis_tready);
    assign accept  = s_axis_tvalid && ready;
    assign sof_acc = accept && s_axis_sof;
    assign match   = ((s_axis_tdata ^ i_prbs) == C_SYNC_WORD);

    // Sequencer: next state, alignment bookkeeping and keystream stepping.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        seen_sof_d  = seen_sof_q;
        step        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_enable) begin
                    state_d     = ST_LOAD;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                    seen_sof_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d     = ST_HUNT;
                match_cnt_d = '0;
                seen_sof_d  = 1'b0;
            end
            ST_HUNT: begin
                if (sof_acc) begin
                    if (match) begin
                        step        = 1'b1;
                        seen_sof_d  = 1'b1;
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_d == LOCK_N) begin
                            state_d    = ST_TRACK;
                            miss_cnt_d = '0;   // fresh hysteresis on every lock
                        end
                    end else begin
                        state_d = ST_LOAD;     // misaligned: reseed and retry
                    end
                end else if (accept && seen_sof_q) begin
                    step = 1'b1;               // pre-SOF junk never steps
                end
            end
            ST_TRACK: begin
                if (accept) begin
                    step = 1'b1;
                    if (s_axis_sof) begin
                        if (match) begin
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                            if (miss_cnt_d == UNLOCK_N) state_d = ST_LOAD;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!i_rx_enable) state_d = ST_IDLE;
    end

    // Status counters and the output beat register.
    always_comb begin
        err_d   = err_q;
        frame_d = frame_q;
        mvld_d  = mvld_q;
        msof_d  = msof_q;
        mdata_d = mdata_q;
        if (state_q == ST_IDLE && i_rx_enable) begin
            err_d   = '0;
            frame_d = '0;
        end else if (sof_acc && state_q == ST_TRACK) begin
            if (match)           frame_d = frame_q + C_CNT_WIDTH'(1);
            else if (err_q != '1) err_d  = err_q + C_CNT_WIDTH'(1);
        end
        if (i_clr_stats) begin
            err_d   = '0;
            frame_d = '0;
        end
        if (!i_rx_enable) begin
            mvld_d = 1'b0;
        end else if (accept && state_q == ST_TRACK) begin
            mvld_d  = 1'b1;
            msof_d  = s_axis_sof;
            mdata_d = s_axis_tdata ^ i_prbs;
        end else if (m_axis_tready) begin
            mvld_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= ST_IDLE;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            seen_sof_q  <= 1'b0;
            err_q       <= '0;
            frame_q     <= '0;
            mvld_q      <= 1'b0;
            msof_q      <= 1'b0;
            mdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            seen_sof_q  <= seen_sof_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
            mvld_q      <= mvld_d;
            msof_q      <= msof_d;
            mdata_q     <= mdata_d;
        end
    end

    assign s_axis_tready = ready;
    assign o_prbs_step   = step;
    assign o_prbs_load   = (state_q == ST_LOAD);
    assign o_prbs_seed   = (state_q == ST_LOAD) ? i_prbs_seed : 32'd0;
    assign m_axis_tvalid = mvld_q;
    assign m_axis_sof    = msof_q;
    assign m_axis_tdata  = mdata_q;
    assign o_locked      = (state_q == ST_TRACK);
    assign o_state       = state_q;
    assign o_err_count   = err_q;
    assign o_frame_count = frame_q;

endmodule
